eth_pcs_rx_gearbox: RTL

RX gearbox between the PMA/SerDes receive interface and the RX block synchroniser. It packs 32-bit PMA words into 66-bit blocks, each a 2-bit sync header plus a 64-bit payload, and presents them with a valid strobe. It accepts the slip request from the block synchroniser and, for each slip, discards one received bit so that block boundaries move by one bit position.

---
 rtl/eth_pcs_rx_gearbox.sv | 69 ++++++
 1 files changed

// File: rtl/eth_pcs_rx_gearbox.sv
// RX gearbox: packs 32-bit PMA words into 66-bit blocks (2-bit sync header + 64-bit payload)
// and drops one received bit per slip request so the block boundary moves by one bit.
module eth_pcs_rx_gearbox #(
  parameter int unsigned W_IN   = 32,
  parameter int unsigned W_SYNC = 2,
  parameter int unsigned W_PAY  = 64,
  parameter int unsigned W_CNT  = 7
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic [W_IN-1:0]   i_data,
  input  logic              i_slip,
  output logic              o_valid,
  output logic [W_SYNC-1:0] o_sync_hdr,
  output logic [W_PAY-1:0]  o_data
);

  localparam int unsigned W_BLK = W_SYNC + W_PAY;
  localparam int unsigned W_BUF = W_BLK + W_IN;

  logic [W_BUF-1:0] bit_buf_q;
  logic [W_CNT-1:0] cnt_q;
  logic             slip_pend_q;

  logic [W_BUF-1:0] merged;
  logic [W_CNT-1:0] tot;
  logic             emit;

  // Append the new word above the held bits; a slip removes the oldest bit.
  always_comb begin
    merged = bit_buf_q | (W_BUF'(i_data) << cnt_q);
    tot    = cnt_q + W_CNT'(W_IN);
    if (i_slip || slip_pend_q) begin
      merged = merged >> 1;
      tot    = tot - W_CNT'(1);
    end
    emit = (tot >= W_CNT'(W_BLK));
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      bit_buf_q   <= '0;
      cnt_q       <= '0;
      slip_pend_q <= 1'b0;
      o_valid     <= 1'b0;
      o_sync_hdr  <= '0;
      o_data      <= '0;
    end else if (i_valid) begin
      slip_pend_q <= 1'b0;
      if (emit) begin
        o_valid    <= 1'b1;
        o_sync_hdr <= merged[W_SYNC-1:0];
        o_data     <= merged[W_BLK-1:W_SYNC];
        bit_buf_q  <= merged >> W_BLK;
        cnt_q      <= tot - W_CNT'(W_BLK);
      end else begin
        o_valid    <= 1'b0;
        bit_buf_q  <= merged;
        cnt_q      <= tot;
      end
    end else begin
      // Idle word: hold the buffer and remember a slip for the next valid word.
      o_valid <= 1'b0;
      if (i_slip) slip_pend_q <= 1'b1;
    end
  end

endmodule
